// File: rtl/sd_clk_divider_ctrl.sv
// sd_clk_divider_ctrl: SD card clock generator.
// Divides PCLK_i into a 50%-duty SD clock. The clock always parks low when it
// stops. Divider changes take effect only at high->low transitions.
// Also produces rise/fall strobes and a stability flag.
// Optional idle auto-gating is built in when SD_CLK_AUTOGATE_EN is defined.
module sd_clk_divider_ctrl #(
  parameter int unsigned DIV_W         = 16,
  parameter int unsigned INIT_DIV      = 127,
  parameter int unsigned STABLE_CYCLES = 8,
  parameter int unsigned IDLE_CYCLES   = 8
) (
  input  logic             PCLK_i,
  input  logic             PRESETn_i,
  input  logic             clk_enable,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_load_i,
  output logic             div_ack_o,
  output logic [DIV_W-1:0] cur_div_o,
  input  logic             bus_busy_i,
  output logic             sd_clk_o,
  output logic             sd_clk_rise_o,
  output logic             sd_clk_fall_o,
  output logic             clk_running_o,
  output logic             clk_stable_o
);

  localparam logic [0:0] ST_STOPPED = 1'b0;
  localparam logic [0:0] ST_RUN     = 1'b1;

  localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

  logic [0:0]       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             sd_clk_q, sd_clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             ack_q, ack_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic             pend_q, pend_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic [7:0]       rise_cnt_q, rise_cnt_d;
  logic             stable_q, stable_d;

  logic             fall_event;
  logic             gate_ok;
  logic             run_ok;
  logic             apply;
  logic             stop;

  assign fall_event = (state_q == ST_RUN) && sd_clk_q && (cnt_q == '0);

`ifdef SD_CLK_AUTOGATE_EN
  logic       gate_open_q, gate_open_d;
  logic [7:0] idle_cnt_q, idle_cnt_d;
  logic       close_now;

  // Idle tracking: count falling edges without bus activity, close the gate at the limit.
  always_comb begin
    gate_open_d = gate_open_q;
    idle_cnt_d  = idle_cnt_q;
    close_now   = 1'b0;
    if (bus_busy_i) begin
      idle_cnt_d  = '0;
      gate_open_d = 1'b1;
    end else if (fall_event && gate_open_q) begin
      if ((idle_cnt_q + 8'd1) >= 8'(IDLE_CYCLES)) begin
        close_now   = 1'b1;
        gate_open_d = 1'b0;
        idle_cnt_d  = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + 8'd1;
      end
    end
  end

  // Gate state registers.
  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      gate_open_q <= 1'b1;
      idle_cnt_q  <= '0;
    end else begin
      gate_open_q <= gate_open_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

  // Closing at a falling edge stops the clock in that same edge.
  assign gate_ok = gate_open_q && !close_now;
`else
  logic       unused_bus_busy;
  logic [7:0] unused_idle_cycles;
  assign unused_bus_busy    = bus_busy_i;
  assign unused_idle_cycles = 8'(IDLE_CYCLES);
  assign gate_ok            = 1'b1;
`endif

  assign run_ok = clk_enable && gate_ok;

  // Next-state logic: run/stop control, half-period counter, divider apply, stability.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sd_clk_d   = sd_clk_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    ack_d      = 1'b0;
    cur_div_d  = cur_div_q;
    pend_d     = pend_q;
    pend_div_d = pend_div_q;
    rise_cnt_d = rise_cnt_q;
    stable_d   = stable_q;
    apply      = 1'b0;
    stop       = 1'b0;

    case (state_q)
      ST_STOPPED: begin
        apply = pend_q;
        if (run_ok) begin
          state_d = ST_RUN;
          // A divider applied in the same edge is the one the first half uses.
          cnt_d   = pend_q ? pend_div_q : cur_div_q;
        end
      end
      default: begin
        if (!sd_clk_q && !run_ok) begin
          stop = 1'b1;
        end else if (cnt_q == '0) begin
          if (sd_clk_q) begin
            sd_clk_d = 1'b0;
            fall_d   = 1'b1;
            apply    = pend_q;
            cnt_d    = pend_q ? pend_div_q : cur_div_q;
            stop     = !run_ok;
          end else begin
            sd_clk_d = 1'b1;
            rise_d   = 1'b1;
            cnt_d    = cur_div_q;
            if (rise_cnt_q < STABLE_N) begin
              rise_cnt_d = rise_cnt_q + 8'd1;
            end
            stable_d = (rise_cnt_d == STABLE_N);
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
    endcase

    if (stop) begin
      state_d = ST_STOPPED;
    end
    if (stop || apply) begin
      rise_cnt_d = '0;
      stable_d   = 1'b0;
    end
    if (apply) begin
      cur_div_d = pend_div_q;
      ack_d     = 1'b1;
      pend_d    = 1'b0;
    end
    // A load in the application cycle becomes the next pending value.
    if (div_load_i) begin
      pend_d     = 1'b1;
      pend_div_d = div_i;
    end
  end

  // State registers.
  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      state_q    <= ST_STOPPED;
      cnt_q      <= '0;
      sd_clk_q   <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      ack_q      <= 1'b0;
      cur_div_q  <= DIV_W'(INIT_DIV);
      pend_q     <= 1'b0;
      pend_div_q <= '0;
      rise_cnt_q <= '0;
      stable_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sd_clk_q   <= sd_clk_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      ack_q      <= ack_d;
      cur_div_q  <= cur_div_d;
      pend_q     <= pend_d;
      pend_div_q <= pend_div_d;
      rise_cnt_q <= rise_cnt_d;
      stable_q   <= stable_d;
    end
  end

  assign sd_clk_o      = sd_clk_q;
  assign sd_clk_rise_o = rise_q;
  assign sd_clk_fall_o = fall_q;
  assign div_ack_o     = ack_q;
  assign cur_div_o     = cur_div_q;
  assign clk_running_o = (state_q == ST_RUN);
  assign clk_stable_o  = stable_q;

endmodule

// File: tb/tb_sd_clk_divider_ctrl.sv
// Self-checking bench for sd_clk_divider_ctrl: vector table for start-up,
// then directed sequences for divider change, stop, stability, reset, and
// (with SD_CLK_AUTOGATE_EN) idle gating.
module tb_sd_clk_divider_ctrl;

  logic        PCLK_i = 1'b0;
  logic        PRESETn_i = 1'b0;
  logic        clk_enable = 1'b0;
  logic [15:0] div_i = '0;
  logic        div_load_i = 1'b0;
  logic        bus_busy_i = 1'b1;
  logic        div_ack_o;
  logic [15:0] cur_div_o;
  logic        sd_clk_o;
  logic        sd_clk_rise_o;
  logic        sd_clk_fall_o;
  logic        clk_running_o;
  logic        clk_stable_o;

  sd_clk_divider_ctrl #(
    .DIV_W(16),
    .INIT_DIV(127),
    .STABLE_CYCLES(8),
    .IDLE_CYCLES(2)
  ) dut (
    .PCLK_i(PCLK_i),
    .PRESETn_i(PRESETn_i),
    .clk_enable(clk_enable),
    .div_i(div_i),
    .div_load_i(div_load_i),
    .div_ack_o(div_ack_o),
    .cur_div_o(cur_div_o),
    .bus_busy_i(bus_busy_i),
    .sd_clk_o(sd_clk_o),
    .sd_clk_rise_o(sd_clk_rise_o),
    .sd_clk_fall_o(sd_clk_fall_o),
    .clk_running_o(clk_running_o),
    .clk_stable_o(clk_stable_o)
  );

  always #5 PCLK_i = ~PCLK_i;

  int n_checks = 0;
  int n_fail   = 0;

  // {sd_clk, rise, fall, ack, running, stable, cur_div}
  typedef struct {
    logic        en;
    logic        load;
    logic [15:0] div;
    logic [21:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK_i);
    #1;
  endtask

  // Step until the chosen strobe is seen; n = cycles taken.
  task automatic wait_strobe(input string name, input bit want_fall, input int budget, output int n);
    logic s;
    n = 0;
    do begin
      step();
      n++;
      s = want_fall ? sd_clk_fall_o : sd_clk_rise_o;
    end while (s !== 1'b1 && n < budget);
    chk({name, " strobe seen"}, 32'(s), 32'd1);
  endtask

  function automatic logic [21:0] mk(input logic sd, input logic r, input logic f,
                                     input logic a, input logic run, input logic st,
                                     input logic [15:0] cd);
    return {sd, r, f, a, run, st, cd};
  endfunction

  initial begin
    int n;
    int rises;
    logic ack_seen;

    vecs[0]  = '{1'b0, 1'b1, 16'd1, mk(0, 0, 0, 0, 0, 0, 16'd127)};
    vecs[1]  = '{1'b0, 1'b0, 16'd0, mk(0, 0, 0, 1, 0, 0, 16'd1)};
    vecs[2]  = '{1'b1, 1'b0, 16'd0, mk(0, 0, 0, 0, 1, 0, 16'd1)};
    vecs[3]  = '{1'b1, 1'b0, 16'd0, mk(0, 0, 0, 0, 1, 0, 16'd1)};
    vecs[4]  = '{1'b1, 1'b0, 16'd0, mk(1, 1, 0, 0, 1, 0, 16'd1)};
    vecs[5]  = '{1'b1, 1'b0, 16'd0, mk(1, 0, 0, 0, 1, 0, 16'd1)};
    vecs[6]  = '{1'b1, 1'b0, 16'd0, mk(0, 0, 1, 0, 1, 0, 16'd1)};
    vecs[7]  = '{1'b1, 1'b0, 16'd0, mk(0, 0, 0, 0, 1, 0, 16'd1)};
    vecs[8]  = '{1'b1, 1'b0, 16'd0, mk(1, 1, 0, 0, 1, 0, 16'd1)};
    vecs[9]  = '{1'b1, 1'b0, 16'd0, mk(1, 0, 0, 0, 1, 0, 16'd1)};
    vecs[10] = '{1'b1, 1'b0, 16'd0, mk(0, 0, 1, 0, 1, 0, 16'd1)};
    vecs[11] = '{1'b1, 1'b0, 16'd0, mk(0, 0, 0, 0, 1, 0, 16'd1)};

    // Reset state
    #12;
    chk("reset outputs",
        32'({sd_clk_o, sd_clk_rise_o, sd_clk_fall_o, div_ack_o, clk_running_o, clk_stable_o, cur_div_o}),
        32'(mk(0, 0, 0, 0, 0, 0, 16'd127)));
    #6;
    PRESETn_i = 1'b1;
    step();

    // Basic start at div 1 from the vector table
    for (int i = 0; i < 12; i++) begin
      clk_enable = vecs[i].en;
      div_load_i = vecs[i].load;
      div_i      = vecs[i].div;
      step();
      chk($sformatf("start vec%0d", i),
          32'({sd_clk_o, sd_clk_rise_o, sd_clk_fall_o, div_ack_o, clk_running_o, clk_stable_o, cur_div_o}),
          32'(vecs[i].exp));
    end
    div_load_i = 1'b0;

    // Stability: two rises already seen in the table; stable must coincide with the 8th
    rises = 2;
    n = 0;
    do begin
      step();
      n++;
      if (sd_clk_rise_o === 1'b1) rises++;
    end while (clk_stable_o !== 1'b1 && n < 100);
    chk("stable rises count", 32'(rises), 32'd8);
    chk("stable with rise strobe", 32'(sd_clk_rise_o), 32'd1);

    // Mid-run divider change to 3, loaded during the high half
    div_i = 16'd3;
    div_load_i = 1'b1;
    step();
    div_load_i = 1'b0;
    wait_strobe("div3 fall", 1'b1, 20, n);
    chk("div3 fall delay", 32'(n), 32'd1);
    chk("div3 ack", 32'(div_ack_o), 32'd1);
    chk("div3 cur", 32'(cur_div_o), 32'd3);
    chk("stable drops on apply", 32'(clk_stable_o), 32'd0);
    wait_strobe("div3 low", 1'b0, 20, n);
    chk("div3 low half", 32'(n), 32'd4);

    // Change to div 0 during the high half of div 3
    div_i = 16'd0;
    div_load_i = 1'b1;
    step();
    div_load_i = 1'b0;
    wait_strobe("div0 fall", 1'b1, 20, n);
    chk("div3 high half", 32'(n + 1), 32'd4);
    chk("div0 ack", 32'({div_ack_o, cur_div_o}), 32'({1'b1, 16'd0}));
    wait_strobe("div0 low", 1'b0, 20, n);
    chk("div0 low half", 32'(n), 32'd1);
    wait_strobe("div0 high", 1'b1, 20, n);
    chk("div0 high half", 32'(n), 32'd1);
    wait_strobe("div0 low2", 1'b0, 20, n);
    chk("div0 period", 32'(n), 32'd1);

    // Stop: clock is high here, must finish with a falling edge
    clk_enable = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (clk_running_o === 1'b1 && n < 20);
    chk("stop from div0 latency", 32'(n), 32'd1);
    chk("stopped low", 32'({sd_clk_o, clk_stable_o, clk_running_o}), 32'd0);

    // Stop while high at div 4
    div_i = 16'd4;
    div_load_i = 1'b1;
    step();
    div_load_i = 1'b0;
    step();
    chk("div4 apply stopped", 32'({div_ack_o, cur_div_o}), 32'({1'b1, 16'd4}));
    clk_enable = 1'b1;
    step();
    chk("div4 run entry", 32'({clk_running_o, div_ack_o, sd_clk_o}), 32'b100);
    wait_strobe("div4 rise", 1'b0, 20, n);
    chk("div4 first rise", 32'(n), 32'd5);
    step();
    step();
    clk_enable = 1'b0;
    wait_strobe("div4 stop fall", 1'b1, 20, n);
    chk("div4 high completes", 32'(n + 2), 32'd5);
    chk("div4 stop state", 32'({clk_running_o, sd_clk_o, clk_stable_o}), 32'd0);
    step();
    chk("after stop", 32'({sd_clk_o, sd_clk_fall_o, sd_clk_rise_o, clk_running_o}), 32'd0);

    // Stop while low: immediate, no strobe
    clk_enable = 1'b1;
    step();
    clk_enable = 1'b0;
    step();
    chk("stop low immediate",
        32'({clk_running_o, sd_clk_o, sd_clk_rise_o, sd_clk_fall_o}), 32'd0);

    // Reset mid-high with a pending divider
    clk_enable = 1'b1;
    step();
    wait_strobe("pre-reset rise", 1'b0, 20, n);
    step();
    div_i = 16'd9;
    div_load_i = 1'b1;
    step();
    div_load_i = 1'b0;
    clk_enable = 1'b0;
    chk("high before reset", 32'(sd_clk_o), 32'd1);
    #2;
    PRESETn_i = 1'b0;
    #1;
    chk("async reset",
        32'({sd_clk_o, sd_clk_rise_o, clk_running_o, cur_div_o}), 32'({3'b000, 16'd127}));
    #3;
    PRESETn_i = 1'b1;
    ack_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (div_ack_o !== 1'b0) ack_seen = 1'b1;
    end
    chk("no ack after reset", 32'(ack_seen), 32'd0);
    chk("cur after reset", 32'(cur_div_o), 32'd127);

`ifdef SD_CLK_AUTOGATE_EN
    // Auto-gate with IDLE_CYCLES = 2 at div 1
    div_i = 16'd1;
    div_load_i = 1'b1;
    step();
    div_load_i = 1'b0;
    step();
    chk("gate div1 apply", 32'({div_ack_o, cur_div_o}), 32'({1'b1, 16'd1}));
    clk_enable = 1'b1;
    step();
    wait_strobe("gate rise", 1'b0, 20, n);
    chk("gate first rise", 32'(n), 32'd2);
    bus_busy_i = 1'b0;
    wait_strobe("gate fall1", 1'b1, 20, n);
    chk("gate still running", 32'(clk_running_o), 32'd1);
    wait_strobe("gate fall2", 1'b1, 20, n);
    chk("gate closed", 32'({clk_running_o, sd_clk_o}), 32'd0);
    bus_busy_i = 1'b1;
    step();
    chk("gate reopen pending", 32'(clk_running_o), 32'd0);
    step();
    chk("gate restart", 32'(clk_running_o), 32'd1);
    wait_strobe("gate restart rise", 1'b0, 20, n);
    chk("gate restart rise delay", 32'(n), 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Strobes must never be high together
  always @(negedge PCLK_i) begin
    if (PRESETn_i && sd_clk_rise_o && sd_clk_fall_o) begin
      n_fail++;
      $display("FAIL strobe overlap: rise=%0b fall=%0b, expected not both 1", sd_clk_rise_o, sd_clk_fall_o);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

endmodule
